// File: rtl/seq_detect_param_pkg.sv
// Shared helpers for the serial pattern detector: length legality and mask generation.
package seq_detect_param_pkg;

  localparam int unsigned MASK_MAX_W = 32;

  // Low-len-bits-set mask, wide enough for any supported MAX_LEN; callers truncate.
  function automatic logic [MASK_MAX_W-1:0] low_mask(input int unsigned len);
    logic [MASK_MAX_W-1:0] m;
    if (len >= MASK_MAX_W) m = '1;
    else                   m = (MASK_MAX_W'(1) << len) - MASK_MAX_W'(1);
    return m;
  endfunction

  function automatic logic len_illegal(input int unsigned len, input int unsigned max_len);
    return (len == 0) || (len > max_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that clears synchronously and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                   q_d = '0;
    else if (inc && q_q != '1) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect_defs.vh
// Reset defaults for the serial pattern detector and the cfg_len sizing rule.
// Shared between the design and its bench so both agree on the power-up detector.
`ifndef SEQ_DETECT_DEFS_VH
`define SEQ_DETECT_DEFS_VH

`define SEQ_DEF_PATTERN 8'b0011_1001
`define SEQ_DEF_LEN     6
`define SEQ_DEF_OVERLAP 1'b1

// cfg_len must be able to represent MAX_LEN itself.
`define SEQ_LEN_W(max_len) ($clog2((max_len) + 1))

`endif

// File: rtl/seq_detect_param.sv
// Programmable serial bit-pattern detector with a registered match pulse and a
// saturating match counter; run-time pattern/length/overlap, defaults from seq_detect_defs.vh.
`include "seq_detect_defs.vh"

module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = `SEQ_LEN_W(MAX_LEN),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(`SEQ_DEF_PATTERN),
  parameter logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(`SEQ_DEF_LEN),
  parameter logic               DEF_OVERLAP = `SEQ_DEF_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic DEF_ERR = len_illegal(int'(DEF_LEN), MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic               err_q,  err_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_p1;
  logic               hit;

  assign cand    = {hist_q[MAX_LEN-2:0], in_bit};
  assign mask    = MAX_LEN'(low_mask(int'(len_q)));
  assign fill_p1 = {1'b0, fill_q} + (LEN_W+1)'(1);

  // A config write in the same cycle swallows the bit, so it can never hit.
  assign hit = in_valid && !cfg_we && !err_q &&
               (fill_p1 >= {1'b0, len_q}) &&
               (((cand ^ pat_q) & mask) == '0);

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = hit;
    if (cfg_we) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      err_d   = len_illegal(int'(cfg_len), MAX_LEN);
      hist_d  = '0;
      fill_d  = '0;
      match_d = 1'b0;
    end else if (in_valid) begin
      hist_d = cand;
      if (hit && !ovl_q)         fill_d = '0;
      else if (fill_q != FILL_MAX) fill_d = fill_p1[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEF_PATTERN;
      len_q   <= DEF_LEN;
      ovl_q   <= DEF_OVERLAP;
      err_q   <= DEF_ERR;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cfg_we),
    .inc (hit),
    .q   (match_count)
  );

  assign match   = match_q;
  assign cfg_err = err_q;

endmodule
